// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/half/word accesses over a word-wide memory port, sign/zero extension.
// Optional macro LSU_MISALIGNED_SPLIT_EN: perform misaligned accesses, split across two words when needed.

module load_store_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              mem_r,
   output logic [3:0]        mem_w,
   output logic [31:0]       mem_in,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_out
);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

   state_t              state, state_nxt;
   logic                we_q;
   logic [2:0]          funct3_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic                err_q;
   logic                split_q;
   logic [31:0]         word0;
   logic [23:0]         word1;   // at most three bytes of the upper word reach the result

   logic                accept;
   logic                req_bad_code;
   logic                req_bad;
   logic                req_split;

   assign req_ready = rst_n && (state == IDLE);
   assign accept    = req_valid && req_ready;

   // Loads accept funct3 0,1,2,4,5; stores accept 0,1,2.
   assign req_bad_code = req_we ? (req_funct3 >= 3'b011)
                                : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);

`ifdef LSU_MISALIGNED_SPLIT_EN
   logic [2:0] req_bytes;

   always_comb begin
      case (req_funct3[1:0])
         2'd1:    req_bytes = 3'd2;
         2'd2:    req_bytes = 3'd4;
         default: req_bytes = 3'd1;
      endcase
   end

   assign req_bad   = req_bad_code;
   assign req_split = ({1'b0, req_addr[1:0]} + req_bytes) > 3'd4;
`else
   logic req_misaligned;

   assign req_misaligned = (req_funct3[1:0] == 2'd1 && req_addr[0])
                        || (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'b00);
   assign req_bad   = req_bad_code || req_misaligned;
   assign req_split = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: datapath registers are reset too; the response mux reads them and must never expose X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= '0;
         wdata_q  <= 32'd0;
         err_q    <= 1'b0;
         split_q  <= 1'b0;
         word0    <= 32'd0;
         word1    <= 24'd0;
      end else begin
         if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            err_q    <= req_bad;
            split_q  <= req_split;
            word1    <= 24'd0;
         end
         if (state == ACC0) word0 <= mem_out;
         if (state == ACC1) word1 <= mem_out[23:0];
      end
   end

   // Store lanes: the low half feeds ACC0, the high half spills into ACC1.
   logic [3:0]         size_mask;
   logic [7:0]         strobe_wide;
   logic [63:0]        wdata_wide;
   logic [ADDR_W-3:0]  word_idx;
   logic [ADDR_W-1:0]  addr_lo;
   logic [ADDR_W-1:0]  addr_hi;

   always_comb begin
      case (funct3_q[1:0])
         2'd0:    size_mask = 4'b0001;
         2'd1:    size_mask = 4'b0011;
         default: size_mask = 4'b1111;
      endcase
   end

   assign strobe_wide = {4'b0000, size_mask} << addr_q[1:0];
   assign wdata_wide  = {32'd0, wdata_q} << {addr_q[1:0], 3'b000};
   assign word_idx    = addr_q[ADDR_W-1:2];
   assign addr_lo     = {word_idx, 2'b00};
   assign addr_hi     = {word_idx + (ADDR_W-2)'(1), 2'b00};

   // Load path: select the bytes starting at the offset, then extend to 32 bits.
   logic [31:0] rd_word;
   logic [31:0] rd_ext;
   logic        sign_en;

   assign sign_en = !funct3_q[2];

   always_comb begin
      case (addr_q[1:0])
         2'd0:    rd_word = word0;
         2'd1:    rd_word = {word1[7:0],  word0[31:8]};
         2'd2:    rd_word = {word1[15:0], word0[31:16]};
         default: rd_word = {word1[23:0], word0[31:24]};
      endcase
   end

   always_comb begin
      case (funct3_q[1:0])
         2'd0:    rd_ext = {{24{sign_en & rd_word[7]}},  rd_word[7:0]};
         2'd1:    rd_ext = {{16{sign_en & rd_word[15]}}, rd_word[15:0]};
         default: rd_ext = rd_word;
      endcase
   end

   // NOTE: every output and next state gets a default first so no latch can be inferred.
   always_comb begin
      state_nxt = state;
      mem_r     = 1'b0;
      mem_w     = 4'b0000;
      mem_in    = 32'd0;
      mem_addr  = '0;
      rsp_valid = 1'b0;
      rsp_rdata = 32'd0;
      rsp_err   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = req_bad ? RESP : ACC0;
         end
         ACC0: begin
            mem_addr = addr_lo;
            if (we_q) begin
               mem_w  = strobe_wide[3:0];
               mem_in = wdata_wide[31:0];
            end else begin
               mem_r = 1'b1;
            end
            state_nxt = split_q ? ACC1 : RESP;
         end
         ACC1: begin
            mem_addr = addr_hi;
            if (we_q) begin
               mem_w  = strobe_wide[7:4];
               mem_in = wdata_wide[63:32];
            end else begin
               mem_r = 1'b1;
            end
            state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            rsp_rdata = (we_q || err_q) ? 32'd0 : rd_ext;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of req_addr and mem_addr.
REQ-002 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req_valid  in  1  access request present.
REQ-005 SHALL have ports: req_ready  out  1  unit can accept a request.
REQ-006 SHALL have ports: req_we  in  1  1 = store, 0 = load.
REQ-007 SHALL have ports: req_funct3  in  3  RV32I width code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 SHALL have ports: req_addr  in  ADDR_W  byte address; req_wdata  in  32  store data (LSB-aligned).
REQ-009 SHALL have ports: rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  32  extended load data; rsp_err  out  1  access rejected.
REQ-010 SHALL have ports: mem_r  out  1  read enable; mem_w  out  4  byte write strobes; mem_in  out  32  write data; mem_addr  out  ADDR_W  word address (bits [1:0] = 0); mem_out  in  32  combinational read data.

Function
REQ-011 SHALL implement states IDLE, ACC0, ACC1, RESP; req_ready = 1 only in IDLE with rst_n high.
REQ-012 SHALL latch we, funct3, addr, wdata on the rising edge where req_valid && req_ready, then enter ACC0, or RESP with error (REQ-019).
REQ-013 SHALL decode size from funct3[1:0] (0 byte, 1 half, 2 word); loads sign-extend unless funct3[2]=1.
REQ-014 In ACC0 SHALL drive mem_addr = {addr[ADDR_W-1:2],2'b00}; load: mem_r=1, mem_w=0; store: mem_r=0, mem_w = (size mask << addr[1:0]) truncated to 4 bits, mem_in = wdata << 8*addr[1:0].
REQ-015 SHALL capture mem_out into word0 at the rising edge ending ACC0 (and into word1 ending ACC1); mem_r/mem_w SHALL be 0 in IDLE and RESP.
REQ-016 Load result SHALL be ({word1,word0} >> 8*addr[1:0])[31:0] masked to size then extended; word1 = 0 when ACC1 not used; stores return rsp_rdata = 0.
REQ-017 RESP SHALL last exactly one cycle with rsp_valid=1, then IDLE; no response backpressure.
REQ-018 Latency: single access rsp_valid high in the 2nd cycle after the accept edge; split access in the 3rd.
REQ-019 Invalid funct3 (load 3'b011, 3'b110, 3'b111; store funct3 >= 3'b011) SHALL go directly to RESP with rsp_err=1 and no memory access.
REQ-020 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid = 0.

Reset
REQ-021 rst_n low SHALL immediately force state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_r=0, mem_w=4'b0000, mem_in=0, mem_addr=0.
REQ-022 Reset during ACC0/ACC1 SHALL abort the access; mem_w drops asynchronously so no byte is written at the following falling edge; no response is issued.

Configuration
REQ-023 Macro LSU_MISALIGNED_SPLIT_EN undefined: any access with addr not a multiple of its size SHALL complete as in REQ-019 (rsp_err=1, no access).
REQ-024 Macro LSU_MISALIGNED_SPLIT_EN defined: misaligned accesses SHALL be performed; if addr[1:0] + size_bytes <= 4, single ACC0 access; otherwise ACC0 then ACC1.
REQ-025 In ACC1 SHALL drive mem_addr = word0 address + 4; store mem_w = full size mask >> (4 - addr[1:0]), mem_in = wdata >> 8*(4 - addr[1:0]); load mem_r=1.

Verification
REQ-026 SW 0xDEADBEEF @0x10 -> ACC0 mem_addr=0x10, mem_w=4'b1111, mem_in=0xDEADBEEF; then LW @0x10 -> rsp_rdata=0xDEADBEEF, rsp_valid 2 cycles after accept.
REQ-027 SB wdata 0x00000080 @0x13 -> mem_w=4'b1000, mem_in=0x80000000; LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080.
REQ-028 LH @0x11: macro undefined -> rsp_err=1, mem_r never high; macro defined -> single access, rsp_rdata = sign-extended bytes 0x12,0x11.
REQ-029 Macro defined, SW 0x11223344 @0x0E -> ACC0 addr 0x0C, mem_w=4'b1100, mem_in=0x33440000; ACC1 addr 0x10, mem_w=4'b0011, mem_in=0x00001122; rsp_valid 3 cycles after accept; LW @0x0E returns 0x11223344.
REQ-030 Load with funct3=3'b011 @0x00 -> rsp_err=1, rsp_rdata=0, mem_r/mem_w 0 throughout.
REQ-031 rst_n low mid-ACC0 of SW 0xFFFFFFFF @0x20 -> mem_w=0 immediately, word @0x20 unchanged, no rsp_valid, req_ready=1 one cycle after release.
